// File: rtl/acp_pkg.sv
// Shared constants, channel state encodings and address helpers
// for the ACP BRAM slave.
package acp_pkg;

  localparam int ID_W   = 3;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // True when a burst starts below base or its last word reaches base+span
  function automatic logic out_of_range(
    input logic [31:0] addr,
    input logic [3:0]  len,
    input logic [31:0] base,
    input logic [32:0] span
  );
    logic [32:0] first;
    logic [32:0] last;
    first = {1'b0, addr[31:3], 3'b000};
    last  = first + {26'd0, len, 3'b000};
    return (first < {1'b0, base}) ||
           (last >= ({1'b0, base} + span));
  endfunction

endpackage

// File: rtl/acp_bram_slave_if.sv
// AXI3 ACP bus bundle between the DMA master and the BRAM slave.
// Size/burst/cache side-bands are fixed and therefore absent.
interface acp_bram_slave_if;
  import acp_pkg::*;

  logic [ID_W-1:0]   awid;
  logic [31:0]       awaddr;
  logic [3:0]        awlen;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [3:0]        arlen;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/acp_dp_ram.sv
// Dual-port 64-bit RAM: byte-enabled write port, registered
// read-first read port. Contents are never reset.
module acp_dp_ram
  import acp_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [STRB_W-1:0] wbe_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read of the old word gives read-first collisions
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wbe_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/acp_bram_slave.sv
// AXI3 ACP slave serving INCR bursts from a dual-port BRAM.
// Define ACP_SLV_RANGE_CHECK_EN to flag bursts outside the window.
module acp_bram_slave
  import acp_pkg::*;
#(
  parameter int          MEM_DEPTH     = 4096,
  parameter int          MEM_DEPTH_LOG = 12,
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000
) (
  input  logic           s_axi_acp_aclk,
  input  logic           axi_reset,
  acp_bram_slave_if.slave s_axi_acp
);

  localparam int AW = MEM_DEPTH_LOG;
  localparam logic [32:0] SPAN = 33'(MEM_DEPTH) << 3;

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 3);
  endfunction

  logic aw_bad;
  logic ar_bad;

`ifdef ACP_SLV_RANGE_CHECK_EN
  assign aw_bad = out_of_range(s_axi_acp.awaddr, s_axi_acp.awlen,
                               BASE_ADDR, SPAN);
  assign ar_bad = out_of_range(s_axi_acp.araddr, s_axi_acp.arlen,
                               BASE_ADDR, SPAN);
`else
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;
`endif

  w_state_e        w_state_q, w_state_d;
  logic [AW-1:0]   w_ptr_q, w_ptr_d;
  logic [3:0]      w_cnt_q, w_cnt_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic            w_err_q, w_err_d;
  logic            w_rng_q, w_rng_d;

  r_state_e        r_state_q, r_state_d;
  logic [AW-1:0]   r_ptr_q, r_ptr_d;
  logic [3:0]      r_cnt_q, r_cnt_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic            r_rng_q, r_rng_d;
  logic            r_valid_q, r_valid_d;
  logic            r_last_q, r_last_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic ram_we, ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign s_axi_acp.awready = (w_state_q == W_IDLE) && !axi_reset;
  assign s_axi_acp.wready  = (w_state_q == W_DATA) && !axi_reset;
  assign s_axi_acp.bvalid  = (w_state_q == W_RESP) && !axi_reset;
  assign s_axi_acp.bid     = axi_reset ? '0 : w_id_q;
  assign s_axi_acp.bresp   = (!axi_reset && (w_err_q || w_rng_q)) ?
                             RESP_SLVERR : RESP_OKAY;

  assign s_axi_acp.arready = (r_state_q == R_IDLE) && !axi_reset;
  assign s_axi_acp.rvalid  = r_valid_q && !axi_reset;
  assign s_axi_acp.rlast   = r_last_q && !axi_reset;
  assign s_axi_acp.rid     = axi_reset ? '0 : r_id_q;
  assign s_axi_acp.rresp   = (!axi_reset && r_rng_q) ?
                             RESP_SLVERR : RESP_OKAY;
  assign s_axi_acp.rdata   = r_rng_q ? '0 : ram_rdata;

  assign aw_hs = s_axi_acp.awvalid && s_axi_acp.awready;
  assign w_hs  = s_axi_acp.wvalid && s_axi_acp.wready;
  assign b_hs  = s_axi_acp.bvalid && s_axi_acp.bready;
  assign ar_hs = s_axi_acp.arvalid && s_axi_acp.arready;
  assign r_hs  = s_axi_acp.rvalid && s_axi_acp.rready;

  assign ram_we = w_hs && !w_rng_q;

  always_comb begin
    w_state_d = w_state_q;
    w_ptr_d   = w_ptr_q;
    w_cnt_d   = w_cnt_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    w_rng_d   = w_rng_q;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_state_d = W_DATA;
        w_ptr_d   = word_of(s_axi_acp.awaddr);
        w_cnt_d   = s_axi_acp.awlen;
        w_id_d    = s_axi_acp.awid;
        w_err_d   = 1'b0;
        w_rng_d   = aw_bad;
      end
      W_DATA: if (w_hs) begin
        w_ptr_d = w_ptr_q + AW'(1);
        w_cnt_d = w_cnt_q - 4'd1;
        // wlast only audits the burst length, never ends it
        if (s_axi_acp.wlast != (w_cnt_q == 4'd0)) w_err_d = 1'b1;
        if (w_cnt_q == 4'd0) w_state_d = W_RESP;
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_ptr_d   = r_ptr_q;
    r_cnt_d   = r_cnt_q;
    r_id_d    = r_id_q;
    r_rng_d   = r_rng_q;
    r_valid_d = r_valid_q;
    r_last_d  = r_last_q;
    ram_re    = 1'b0;
    ram_raddr = r_ptr_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_DATA;
        ram_re    = 1'b1;
        ram_raddr = word_of(s_axi_acp.araddr);
        r_ptr_d   = word_of(s_axi_acp.araddr) + AW'(1);
        r_cnt_d   = s_axi_acp.arlen;
        r_id_d    = s_axi_acp.arid;
        r_rng_d   = ar_bad;
        r_valid_d = 1'b1;
        r_last_d  = (s_axi_acp.arlen == 4'd0);
      end
      // r_cnt_q counts beats still to be fetched into the RAM register
      R_DATA: if (r_hs) begin
        if (r_last_q) begin
          r_state_d = R_IDLE;
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
        end else begin
          ram_re   = 1'b1;
          r_ptr_d  = r_ptr_q + AW'(1);
          r_cnt_d  = r_cnt_q - 4'd1;
          r_last_d = (r_cnt_q == 4'd1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_acp_aclk) begin
    if (axi_reset) begin
      w_state_q <= W_IDLE;
      w_ptr_q   <= '0;
      w_cnt_q   <= '0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      w_rng_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_ptr_q   <= '0;
      r_cnt_q   <= '0;
      r_id_q    <= '0;
      r_rng_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_ptr_q   <= w_ptr_d;
      w_cnt_q   <= w_cnt_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      w_rng_q   <= w_rng_d;
      r_state_q <= r_state_d;
      r_ptr_q   <= r_ptr_d;
      r_cnt_q   <= r_cnt_d;
      r_id_q    <= r_id_d;
      r_rng_q   <= r_rng_d;
      r_valid_q <= r_valid_d;
      r_last_q  <= r_last_d;
    end
  end

  acp_dp_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (s_axi_acp_aclk),
    .we_i    (ram_we),
    .waddr_i (w_ptr_q),
    .wbe_i   (s_axi_acp.wstrb),
    .wdata_i (s_axi_acp.wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_acp_bram_slave.sv
// Randomized bench for acp_bram_slave against a word-array model.
// Honors ACP_SLV_RANGE_CHECK_EN the same way as the design.
module tb_acp_bram_slave;
  import acp_pkg::*;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acp_bram_slave_if bus();

  acp_bram_slave #(
    .MEM_DEPTH     (DEPTH),
    .MEM_DEPTH_LOG (12),
    .BASE_ADDR     (BASE)
  ) dut (
    .s_axi_acp_aclk (clk),
    .axi_reset      (rst),
    .s_axi_acp      (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];

  task automatic expect_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_idx(input logic [31:0] a, input int i);
    logic [31:0] off;
    off = (a - BASE) >> 3;
    return int'((off % DEPTH + 32'(i)) % DEPTH);
  endfunction

  function automatic bit flagged(input logic [31:0] a, input int len);
`ifdef ACP_SLV_RANGE_CHECK_EN
    longint s;
    s = longint'({a[31:3], 3'b000});
    return (s < longint'(BASE)) ||
           (s + len * 8 >= longint'(BASE) + DEPTH * 8);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_write(input logic [2:0] id, input logic [31:0] a,
                          input int len, input int bad);
    int t, k;
    bit err, fl, lv;
    fl = flagged(a, len);
    err = 1'b0;
    @(negedge clk);
    bus.awid = id; bus.awaddr = a; bus.awlen = 4'(len);
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 50) begin @(negedge clk); t++; end
    expect_eq("awready", bus.awready, 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      lv = (i == len) || (i == bad);
      if (lv != (i == len)) err = 1'b1;
      bus.wdata = wd[i]; bus.wstrb = ws[i];
      bus.wlast = lv; bus.wvalid = 1'b1;
      expect_eq("wready", bus.wready, 1);
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    k = $urandom_range(0, 2);
    for (int j = 0; j <= k; j++) begin
      bus.bready = (j == k);
      expect_eq("bvalid", bus.bvalid, 1);
      expect_eq("bid", bus.bid, id);
      expect_eq("bresp", bus.bresp, (err || fl) ? 2'b10 : 2'b00);
      @(negedge clk);
    end
    bus.bready = 1'b0;
    expect_eq("bvalid_drop", bus.bvalid, 0);
    expect_eq("awready_back", bus.awready, 1);
    if (!fl) begin
      for (int i = 0; i <= len; i++)
        for (int b = 0; b < 8; b++)
          if (ws[i][b])
            ref_mem[word_idx(a, i)][8*b +: 8] = wd[i][8*b +: 8];
    end
  endtask

  // mode 0: rready high, 1: toggling, 2: random
  task automatic do_read(input logic [2:0] id, input logic [31:0] a,
                         input int len, input int mode, input int abort_at);
    int t, beat;
    bit fl, rr, hs;
    logic [63:0] ev;
    fl = flagged(a, len);
    @(negedge clk);
    bus.arid = id; bus.araddr = a; bus.arlen = 4'(len);
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 50) begin @(negedge clk); t++; end
    expect_eq("arready", bus.arready, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    beat = 0; t = 0;
    while (beat <= len && t < 200) begin
      if (beat == abort_at) begin
        rst = 1'b1; bus.rready = 1'b0;
        @(negedge clk);
        expect_eq("rst_rvalid", bus.rvalid, 0);
        expect_eq("rst_rlast", bus.rlast, 0);
        expect_eq("rst_arready", bus.arready, 0);
        rst = 1'b0;
        #1;
        expect_eq("post_rst_arready", bus.arready, 1);
        return;
      end
      ev = fl ? 64'd0 : ref_mem[word_idx(a, beat)];
      expect_eq("rvalid", bus.rvalid, 1);
      expect_eq("rdata", bus.rdata, ev);
      expect_eq("rlast", bus.rlast, beat == len);
      expect_eq("rid", bus.rid, id);
      expect_eq("rresp", bus.rresp, fl ? 2'b10 : 2'b00);
      rr = (mode == 0) ? 1'b1 :
           (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      bus.rready = rr;
      hs = rr && bus.rvalid;
      @(negedge clk);
      if (hs) beat++;
      t++;
    end
    bus.rready = 1'b0;
    expect_eq("beats_done", beat, len + 1);
    expect_eq("rvalid_drop", bus.rvalid, 0);
    expect_eq("arready_back", bus.arready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int len, bad;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    expect_eq("rst_awready", bus.awready, 0);
    expect_eq("rst_wready", bus.wready, 0);
    expect_eq("rst_bvalid", bus.bvalid, 0);
    expect_eq("rst_arready", bus.arready, 0);
    expect_eq("rst_rvalid", bus.rvalid, 0);
    expect_eq("rst_rlast", bus.rlast, 0);
    expect_eq("rst_bresp", bus.bresp, 0);
    expect_eq("rst_rresp", bus.rresp, 0);
    expect_eq("rst_bid", bus.bid, 0);
    expect_eq("rst_rid", bus.rid, 0);
    rst = 1'b0;

    for (int b = 0; b < DEPTH / 16; b++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
      end
      do_write(3'(b), BASE + 32'(b * 128), 15, -1);
    end

    for (int i = 0; i < 16; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
    do_write(3'd5, BASE, 15, -1);
    do_read(3'd6, BASE, 15, 1, -1);

    wd[0] = 64'd0; ws[0] = 8'hFF;
    do_write(3'd1, BASE + 32'h80, 0, -1);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F;
    do_write(3'd2, BASE + 32'h80, 0, -1);
    do_read(3'd3, BASE + 32'h80, 0, 0, -1);
    expect_eq("strb_word", ref_mem[16], 64'h0000_0000_FFFF_FFFF);

    for (int i = 0; i < 16; i++) begin
      wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
    end
    do_write(3'd7, BASE + 32'h200, 15, 3);
    do_read(3'd7, BASE + 32'h200, 15, 2, -1);

    do_read(3'd2, BASE + 32'((DEPTH - 1) * 8), 1, 0, -1);

    do_read(3'd1, BASE, 15, 0, 5);
    do_read(3'd4, BASE, 15, 0, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, DEPTH - 1) * 8)
                    + 32'($urandom_range(0, 7));
      len = $urandom_range(0, 15);
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : -1;
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom);
      end
      do_write(3'($urandom), a, len, bad);
      if ($urandom_range(0, 1) == 0)
        a = BASE + 32'($urandom_range(0, DEPTH - 1) * 8);
      do_read(3'($urandom), a, $urandom_range(0, 15), 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
